// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: registered one-hot grant plus index, held until done or request drop.
// Optional hold timeout compiled in with ARB_TIMEOUT_EN (revokes a grant after MAX_HOLD busy cycles).
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] id_nxt;
  logic       valid_nxt;
  logic       timeout_nxt;
  logic [2:0] win_id;
  logic       win_found;
  logic [2:0] idx;
  logic       release_c;
  logic       expire;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 1..255");
  end

  // Search upward from ptr with natural 3-bit wrap; first set bit wins.
  always_comb begin
    win_id    = 3'd0;
    win_found = 1'b0;
    idx       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!win_found && req[idx]) begin
        win_id    = idx;
        win_found = 1'b1;
      end
    end
  end

  assign release_c = (state == BUSY) && (done || !req[gnt_id]);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  // A normal release on the same edge wins over the timeout.
  assign expire = (state == BUSY) && !release_c && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE || release_c || expire) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    id_nxt      = gnt_id;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = BUSY;
          gnt_nxt   = 8'b1 << win_id;
          id_nxt    = win_id;
          valid_nxt = 1'b1;
        end else begin
          gnt_nxt   = 8'h00;
          valid_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (release_c || expire) begin
          state_nxt   = IDLE;
          gnt_nxt     = 8'h00;
          valid_nxt   = 1'b0;
          ptr_nxt     = gnt_id + 3'd1;
          timeout_nxt = expire;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scenario bench for rr_arbiter8; expected outputs queued per driven cycle and compared after the edge.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    logic       to;
  } obs_t;

  typedef struct {
    logic [7:0] req;
    logic       done;
    obs_t       exp;
  } row_t;

  obs_t exp_q[$];
  obs_t got;
  int   n_cmp = 0;
  int   n_err = 0;

  assign got = {gnt, gnt_id, gnt_valid, timeout};

  function automatic obs_t busy(input int id);
    logic [7:0] one;
    one = 8'h01;
    return {one << id, 3'(id), 1'b1, 1'b0};
  endfunction

  function automatic obs_t idle(input int id, input logic to);
    return {8'h00, 3'(id), 1'b0, to};
  endfunction

  function automatic row_t mk(input logic [7:0] r, input logic d, input obs_t e);
    row_t x;
    x.req  = r;
    x.done = d;
    x.exp  = e;
    return x;
  endfunction

  task automatic test_reset;
    row_t rows[$];
    obs_t e;
    #1 rst_n = 1'b0;
    exp_q.push_back(idle(0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL reset_init: got %h want %h", got, e); end
    rst_n = 1'b1;
    // grant 5, release (ptr 6), grant 6, then reset mid-grant
    rows.push_back(mk(8'h20, 1'b0, busy(5)));
    rows.push_back(mk(8'h20, 1'b1, idle(5, 1'b0)));
    rows.push_back(mk(8'h40, 1'b0, busy(6)));
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL reset_pre[%0d]: got %h want %h", k, got, e); end
    end
    #2 rst_n = 1'b0;
    req = 8'h00; done = 1'b0;
    exp_q.push_back(idle(0, 1'b0));
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL reset_async: got %h want %h", got, e); end
    #1 rst_n = 1'b1;
    rows.delete();
    rows.push_back(mk(8'h00, 1'b0, idle(0, 1'b0)));
    rows.push_back(mk(8'h00, 1'b0, idle(0, 1'b0)));
    rows.push_back(mk(8'hFF, 1'b0, busy(0)));
    rows.push_back(mk(8'h00, 1'b0, idle(0, 1'b0)));
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL reset_post[%0d]: got %h want %h", k, got, e); end
    end
  endtask

  task automatic test_single;
    row_t rows[$];
    obs_t e;
    rows.push_back(mk(8'h04, 1'b0, busy(2)));
    rows.push_back(mk(8'h04, 1'b1, idle(2, 1'b0)));
    rows.push_back(mk(8'hFF, 1'b0, busy(3)));
    rows.push_back(mk(8'hFF, 1'b1, idle(3, 1'b0)));
    rows.push_back(mk(8'h00, 1'b0, idle(3, 1'b0)));
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL single[%0d]: got %h want %h", k, got, e); end
    end
  endtask

  task automatic test_round_robin;
    row_t rows[$];
    obs_t e;
    rows.push_back(mk(8'h80, 1'b0, busy(7)));
    rows.push_back(mk(8'h80, 1'b1, idle(7, 1'b0)));
    // done held high: ignored in IDLE, releases every BUSY cycle
    for (int i = 0; i < 9; i++) begin
      rows.push_back(mk(8'hFF, 1'b1, busy(i % 8)));
      rows.push_back(mk(8'hFF, 1'b1, idle(i % 8, 1'b0)));
    end
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL round_robin[%0d]: got %h want %h", k, got, e); end
    end
  endtask

  task automatic test_rotation_skip;
    row_t rows[$];
    obs_t e;
    rows.push_back(mk(8'h04, 1'b0, busy(2)));
    rows.push_back(mk(8'h04, 1'b1, idle(2, 1'b0)));
    rows.push_back(mk(8'hAA, 1'b1, busy(3)));
    rows.push_back(mk(8'hAA, 1'b1, idle(3, 1'b0)));
    rows.push_back(mk(8'hAA, 1'b1, busy(5)));
    rows.push_back(mk(8'hAA, 1'b1, idle(5, 1'b0)));
    rows.push_back(mk(8'hAA, 1'b1, busy(7)));
    rows.push_back(mk(8'hAA, 1'b1, idle(7, 1'b0)));
    rows.push_back(mk(8'hAA, 1'b1, busy(1)));
    rows.push_back(mk(8'hAA, 1'b1, idle(1, 1'b0)));
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL rotation[%0d]: got %h want %h", k, got, e); end
    end
  endtask

  task automatic test_simultaneous;
    row_t rows[$];
    obs_t e;
    rows.push_back(mk(8'h04, 1'b0, busy(2)));
    rows.push_back(mk(8'h05, 1'b1, idle(2, 1'b0)));
    rows.push_back(mk(8'h05, 1'b0, busy(0)));
    rows.push_back(mk(8'h00, 1'b1, idle(0, 1'b0)));
    rows.push_back(mk(8'h00, 1'b0, idle(0, 1'b0)));
    rows.push_back(mk(8'h01, 1'b0, busy(0)));
    rows.push_back(mk(8'h03, 1'b0, busy(0)));
    rows.push_back(mk(8'h02, 1'b0, idle(0, 1'b0)));
    rows.push_back(mk(8'h02, 1'b0, busy(1)));
    rows.push_back(mk(8'h00, 1'b0, idle(1, 1'b0)));
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL simultaneous[%0d]: got %h want %h", k, got, e); end
    end
  endtask

  task automatic test_drop;
    row_t rows[$];
    obs_t e;
    rows.push_back(mk(8'h10, 1'b0, busy(4)));
    rows.push_back(mk(8'h10, 1'b0, busy(4)));
    rows.push_back(mk(8'h00, 1'b0, idle(4, 1'b0)));
    rows.push_back(mk(8'h30, 1'b0, busy(5)));
    rows.push_back(mk(8'h00, 1'b0, idle(5, 1'b0)));
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL drop[%0d]: got %h want %h", k, got, e); end
    end
  endtask

  task automatic test_timeout;
    row_t rows[$];
    obs_t e;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) rows.push_back(mk(8'h40, 1'b0, busy(6)));
    rows.push_back(mk(8'h40, 1'b0, idle(6, 1'b1)));
    rows.push_back(mk(8'h40, 1'b0, busy(6)));
    for (int i = 0; i < 3; i++) rows.push_back(mk(8'h40, 1'b0, busy(6)));
    rows.push_back(mk(8'h40, 1'b1, idle(6, 1'b0)));
    rows.push_back(mk(8'h00, 1'b0, idle(6, 1'b0)));
`else
    for (int i = 0; i < 110; i++) rows.push_back(mk(8'h40, 1'b0, busy(6)));
    rows.push_back(mk(8'h00, 1'b0, idle(6, 1'b0)));
`endif
    foreach (rows[k]) begin
      req = rows[k].req; done = rows[k].done; exp_q.push_back(rows[k].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if (got !== e) begin n_err++; $display("FAIL timeout[%0d]: got %h want %h", k, got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rotation_skip();
    test_simultaneous();
    test_drop();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters. It grants exactly one requester at a time and holds that grant until the requester signals completion or drops its request. After each grant, priority rotates so the next search starts just above the last winner. It sits in front of the shared 8-to-3 priority-encode path: requests enter as an 8-bit vector, and the grant leaves as both a one-hot vector and a 3-bit index.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum number of BUSY cycles per grant when the timeout is compiled in. Legal range is 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i is requester i. A requester holds its bit high for the whole use of the resource.
- done  input  1  single-cycle release strobe from the current owner.
- gnt  output  8  one-hot grant; all zeros when idle.
- gnt_id  output  3  binary index of the granted requester.
- gnt_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset and idle behaviour:
  - Async reset sets state = IDLE, gnt = 8'h00, gnt_id = 3'd0, gnt_valid = 0, timeout = 0, priority pointer ptr = 3'd0, and hold counter = 0.
- Two states: IDLE and BUSY.
- IDLE:
  - If req != 0, the winner is the first set bit found by searching upward from ptr, wrapping 7 -> 0.
  - On the next edge: state -> BUSY; gnt = 1 << winner; gnt_id = winner; gnt_valid = 1; hold counter = 0.
  - If req == 0, remain in IDLE with all outputs at their reset values; ptr is unchanged.
- BUSY: a grant is released when either of these holds at a clock edge:
  - done = 1, or
  - req[gnt_id] = 0.
- On release: state -> IDLE; gnt = 0; gnt_valid = 0; gnt_id holds its last value; ptr = gnt_id + 1 (mod 8, natural 3-bit wrap).
- Requests from other requesters that change during BUSY have no effect on the current grant.
- Fairness: with all eight requesting continuously, grants follow the order ptr, ptr+1, ... and no requester waits more than 7 grants.
- The done input is ignored in IDLE.

## Timing
- Request-to-grant latency: 1 cycle. req is sampled at edge N in IDLE, and gnt is valid after edge N.
- Release-to-IDLE: 1 cycle. There is always exactly one IDLE cycle between consecutive grants, so the minimum grant period is 2 cycles (1 BUSY + 1 IDLE).
- Grant outputs are registered and glitch-free; there is no combinational path from req to gnt.
- Simultaneous events:
  - done and a new request from another requester on the same edge: release first, then the new request is arbitrated on the following IDLE edge using the updated ptr.
  - done and a dropped req on the same edge: a single release occurs.
- Pointer wrap: a grant to 7 sets ptr = 0.
- Reset mid-grant: outputs clear immediately, asynchronously, with no timeout pulse. After reset deasserts, arbitration restarts from ptr = 0.

## Configuration
- ARB_TIMEOUT_EN, when defined:
  - The hold counter increments on every BUSY cycle that does not release.
  - When the counter reaches MAX_HOLD - 1 and no normal release occurs on that edge, the grant is revoked exactly like a release (ptr advances).
  - timeout pulses high for the following cycle, coincident with the IDLE state.
  - A normal release on the same edge takes precedence, and no timeout pulse is produced.
- ARB_TIMEOUT_EN, when not defined:
  - There is no hold counter, and a grant lasts indefinitely.
  - timeout is tied to 0.
  - The port list is identical in both builds.

## Test plan
- Reset/idle: assert rst_n = 0 mid-BUSY -> gnt = 8'h00, gnt_valid = 0, and timeout = 0 immediately; then release reset with req = 8'h00 -> outputs stay at zero.
- Single request: req = 8'b0000_0100 -> one edge later gnt = 8'h04, gnt_id = 2, gnt_valid = 1; pulse done -> next edge gnt = 0 and ptr = 3.
- Round-robin: hold req = 8'hFF and pulse done on every BUSY cycle -> gnt_id sequence is 0,1,2,...,7,0 with one IDLE cycle between grants.
- Rotation skip: ptr = 3, req = 8'b1010_1010 -> gnt_id = 3; release -> gnt_id = 5; then 7, then 1 (wrap).
- Request drop: grant to 4, then drop req[4] with no done -> the next edge releases, gnt = 0, and ptr = 5.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD = 4): requester 6 holds with no done -> gnt_valid is high for exactly 4 cycles, then timeout = 1 for one cycle with gnt = 0; in the non-EN build, the grant persists for more than 100 cycles and timeout stays 0.
